spi_slave_wr: RTL and testbench

SPI slave receive front-end for the SPI-to-I2C bridge. It samples an external SPI bus (mode 0, MSB first) in the bridge's write-clock domain and assembles serial bytes. Each completed byte is pushed into the write port of the bridge FIFO. The downstream I2C slave drains that FIFO on its read side. Toward the SPI master, the block returns a status byte on MISO and keeps a sticky overflow flag.

---
 rtl/spi_slave_wr_if.sv | 30 +++
 rtl/spi_slave_wr.sv | 143 ++++++++++++++
 tb/tb_spi_slave_wr.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/spi_slave_wr_if.sv
// spi_slave_wr_if
//   Bundles the SPI pins and the FIFO write port of the SPI slave receive
//   front-end.
//   slave modport  : the front-end (samples SPI pins, drives the FIFO push).
//   master modport : the environment (SPI master pins, FIFO full flag).
//   Signals: sclk, cs_n, mosi, miso (SPI); wr_data, wr_en, wr_full (FIFO);
//            overflow, frame_active (status).
interface spi_slave_wr_if #(
  parameter int DATA_W = 8
);
  logic              sclk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic [DATA_W-1:0] wr_data;
  logic              wr_en;
  logic              wr_full;
  logic              overflow;
  logic              frame_active;

  modport slave (
    input  sclk, cs_n, mosi, wr_full,
    output miso, wr_data, wr_en, overflow, frame_active
  );

  modport master (
    output sclk, cs_n, mosi, wr_full,
    input  miso, wr_data, wr_en, overflow, frame_active
  );
endinterface

// File: rtl/spi_slave_wr.sv
// spi_slave_wr
//   SPI (mode 0, MSB first) slave receive front-end. Oversamples the SPI pins
//   in the write-clock domain, assembles DATA_W-bit bytes and pushes each one
//   into the bridge FIFO. Returns a status byte {overflow, wr_full, 0...} on
//   miso as the first byte of every frame; overflow is sticky.
//   Ports:
//     wr_clk   : write-side clock, rising edge
//     wr_rst_n : asynchronous active-low reset
//     bus      : spi_slave_wr_if.slave (SPI pins, FIFO write port, status)
module spi_slave_wr #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wr_clk,
  input  logic             wr_rst_n,
  spi_slave_wr_if.slave    bus
);

  localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                  state_reg;
  logic [SYNC_STAGES-1:0]  sclk_sync_reg;
  logic [SYNC_STAGES-1:0]  cs_sync_reg;
  logic [SYNC_STAGES-1:0]  mosi_sync_reg;
  logic                    sclk_prev_reg;
  logic                    cs_prev_reg;
  logic [CNT_W-1:0]        bit_cnt_reg;
  logic [DATA_W-1:0]       rx_reg;
  logic [DATA_W-1:0]       tx_reg;
  logic [DATA_W-1:0]       wr_data_reg;
  logic                    wr_en_reg;
  logic                    miso_reg;
  logic                    overflow_reg;
  logic                    frame_active_reg;
  logic                    first_byte_reg;   // next completed byte is the frame's first
  logic                    ovf_at_load_reg;  // overflow value carried in this frame's status

  logic                    sclk_s;
  logic                    cs_s;
  logic                    mosi_s;
  logic                    sclk_rise;
  logic                    sclk_fall;
  logic                    cs_fall;
  logic                    cs_rise;
  logic [DATA_W-1:0]       rx_next;

  assign sclk_s    = sclk_sync_reg[SYNC_STAGES-1];
  assign cs_s      = cs_sync_reg[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_reg[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_reg;
  assign sclk_fall = ~sclk_s & sclk_prev_reg;
  assign cs_fall   = ~cs_s & cs_prev_reg;
  assign cs_rise   = cs_s & ~cs_prev_reg;
  assign rx_next   = {rx_reg[DATA_W-2:0], mosi_s};

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      state_reg        <= IDLE;
      sclk_sync_reg    <= '0;
      cs_sync_reg      <= '1;
      mosi_sync_reg    <= '0;
      sclk_prev_reg    <= 1'b0;
      cs_prev_reg      <= 1'b1;
      bit_cnt_reg      <= '0;
      rx_reg           <= '0;
      tx_reg           <= '0;
      wr_data_reg      <= '0;
      wr_en_reg        <= 1'b0;
      miso_reg         <= 1'b1;
      overflow_reg     <= 1'b0;
      frame_active_reg <= 1'b0;
      first_byte_reg   <= 1'b0;
      ovf_at_load_reg  <= 1'b0;
    end else begin
      sclk_sync_reg <= {sclk_sync_reg[SYNC_STAGES-2:0], bus.sclk};
      cs_sync_reg   <= {cs_sync_reg[SYNC_STAGES-2:0], bus.cs_n};
      mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], bus.mosi};
      sclk_prev_reg <= sclk_s;
      cs_prev_reg   <= cs_s;
      wr_en_reg     <= 1'b0;

      case (state_reg)
        IDLE: begin
          miso_reg    <= 1'b1;
          bit_cnt_reg <= '0;
          if (cs_fall) begin
            state_reg        <= ACTIVE;
            frame_active_reg <= 1'b1;
            tx_reg           <= {overflow_reg, bus.wr_full, {(DATA_W-2){1'b0}}};
            miso_reg         <= overflow_reg;
            first_byte_reg   <= 1'b1;
            ovf_at_load_reg  <= overflow_reg;
          end
        end

        ACTIVE: begin
          // Deselect takes priority over any sclk edge seen in the same cycle.
          if (cs_rise) begin
            state_reg        <= IDLE;
            frame_active_reg <= 1'b0;
            bit_cnt_reg      <= '0;
            miso_reg         <= 1'b1;
          end else begin
            if (sclk_rise) begin
              rx_reg <= rx_next;
              if (bit_cnt_reg == CNT_W'(DATA_W-1)) begin
                bit_cnt_reg    <= '0;
                first_byte_reg <= 1'b0;
                if (bus.wr_full) begin
                  // A drop always sets overflow, even on the byte that
                  // would otherwise clear it.
                  overflow_reg <= 1'b1;
                end else begin
                  wr_data_reg <= rx_next;
                  wr_en_reg   <= 1'b1;
                  if (first_byte_reg && ovf_at_load_reg)
                    overflow_reg <= 1'b0;
                end
              end else begin
                bit_cnt_reg <= bit_cnt_reg + 1'b1;
              end
            end
            if (sclk_fall) begin
              tx_reg   <= {tx_reg[DATA_W-2:0], 1'b0};
              miso_reg <= tx_reg[DATA_W-2];
            end
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.miso         = miso_reg;
  assign bus.wr_data      = wr_data_reg;
  assign bus.wr_en        = wr_en_reg;
  assign bus.overflow     = overflow_reg;
  assign bus.frame_active = frame_active_reg;

endmodule

// File: tb/tb_spi_slave_wr.sv
// tb_spi_slave_wr
//   Directed bench for spi_slave_wr. A bit-banged SPI master drives frames;
//   a frame-level model predicts pushed bytes, the status byte returned on
//   miso and the sticky overflow flag. A compare process checks every push.
module tb_spi_slave_wr;

  localparam int HALF = 6;  // wr_clk periods per sclk phase

  logic wr_clk;
  logic wr_rst_n;

  spi_slave_wr_if #(.DATA_W(8)) bus ();

  spi_slave_wr #(.DATA_W(8), .SYNC_STAGES(2)) dut (
    .wr_clk   (wr_clk),
    .wr_rst_n (wr_rst_n),
    .bus      (bus)
  );

  initial wr_clk = 1'b0;
  always #5 wr_clk = ~wr_clk;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Frame-level model state
  logic [7:0] exp_q[$];
  logic       m_ovf;
  logic       m_full;
  logic       m_first;
  logic       m_status_ovf;
  logic [7:0] m_status;
  int         m_byte_idx;
  logic [7:0] last_miso;
  logic [7:0] first_miso;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Compare process: every push must match the next expected byte.
  logic prev_wr_en = 1'b0;
  always @(negedge wr_clk) begin
    if (bus.wr_en === 1'b1) begin
      check("wr_en_single_cycle", {31'b0, prev_wr_en}, 32'd0);
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_push: got 0x%0h expected no push", bus.wr_data);
      end else begin
        check("push_data", {24'b0, bus.wr_data}, {24'b0, exp_q.pop_front()});
      end
    end
    prev_wr_en <= bus.wr_en;
  end

  task automatic wait_clk(input int n);
    repeat (n) @(posedge wr_clk);
    #2;
  endtask

  task automatic frame_begin(input logic full);
    bus.wr_full  = full;
    m_full       = full;
    m_status     = {m_ovf, full, 6'b0};
    m_status_ovf = m_ovf;
    m_first      = 1'b1;
    m_byte_idx   = 0;
    bus.cs_n     = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic send_byte(input logic [7:0] b, input int nbits);
    logic [7:0] mb;
    mb = 8'h00;
    if (nbits == 8) begin
      if (m_full) begin
        m_ovf = 1'b1;
      end else begin
        exp_q.push_back(b);
        if (m_first && m_status_ovf) m_ovf = 1'b0;
      end
      m_first = 1'b0;
    end
    for (int i = 0; i < nbits; i++) begin
      bus.mosi = b[7-i];
      wait_clk(HALF);
      bus.sclk = 1'b1;
      mb = {mb[6:0], bus.miso};
      wait_clk(HALF);
      bus.sclk = 1'b0;
    end
    if (nbits == 8) begin
      last_miso = mb;
      if (m_byte_idx == 0) begin
        first_miso = mb;
        check("miso_status", {24'b0, mb}, {24'b0, m_status});
      end else begin
        check("miso_zero", {24'b0, mb}, 32'd0);
      end
      m_byte_idx++;
    end
  endtask

  task automatic frame_end();
    wait_clk(HALF);
    bus.cs_n = 1'b1;
    wait_clk(10);
    check("pending_pushes", exp_q.size(), 32'd0);
    check("overflow", {31'b0, bus.overflow}, {31'b0, m_ovf});
    check("miso_idle", {31'b0, bus.miso}, 32'd1);
    check("frame_inactive", {31'b0, bus.frame_active}, 32'd0);
  endtask

  initial begin
    m_ovf        = 1'b0;
    m_full       = 1'b0;
    m_first      = 1'b0;
    m_status_ovf = 1'b0;
    m_status     = 8'h00;
    m_byte_idx   = 0;
    last_miso    = 8'h00;
    first_miso   = 8'h00;
    bus.sclk     = 1'b0;
    bus.cs_n     = 1'b1;
    bus.mosi     = 1'b0;
    bus.wr_full  = 1'b0;
    wr_rst_n     = 1'b0;

    wait_clk(3);
    check("rst_wr_en", {31'b0, bus.wr_en}, 32'd0);
    check("rst_wr_data", {24'b0, bus.wr_data}, 32'd0);
    check("rst_miso", {31'b0, bus.miso}, 32'd1);
    check("rst_overflow", {31'b0, bus.overflow}, 32'd0);
    check("rst_frame_active", {31'b0, bus.frame_active}, 32'd0);
    wr_rst_n = 1'b1;
    wait_clk(3);

    // Single byte 0xA5
    frame_begin(1'b0);
    check("frame_active_on", {31'b0, bus.frame_active}, 32'd1);
    send_byte(8'hA5, 8);
    frame_end();
    check("lit_status_clean", {24'b0, first_miso}, 32'h00);

    // Three back-to-back bytes
    frame_begin(1'b0);
    send_byte(8'h25, 8);
    send_byte(8'hAD, 8);
    send_byte(8'hB3, 8);
    frame_end();

    // Drop while FIFO full
    frame_begin(1'b1);
    send_byte(8'h3C, 8);
    frame_end();
    check("lit_status_full", {24'b0, first_miso}, 32'h40);
    check("lit_overflow_set", {31'b0, bus.overflow}, 32'd1);

    // Status reports overflow, first byte clears it, next byte pushed
    frame_begin(1'b0);
    send_byte(8'h77, 8);
    check("lit_status_ovf", {24'b0, first_miso}, 32'h80);
    check("lit_overflow_cleared", {31'b0, bus.overflow}, 32'd0);
    send_byte(8'h11, 8);
    frame_end();

    // Abort after 5 bits, then a clean byte
    frame_begin(1'b0);
    send_byte(8'hFF, 5);
    frame_end();
    frame_begin(1'b0);
    send_byte(8'h5A, 8);
    frame_end();

    // Asynchronous reset in the middle of a byte
    frame_begin(1'b0);
    send_byte(8'hE7, 3);
    wait_clk(2);
    #3 wr_rst_n = 1'b0;
    #1;
    check("midrst_wr_en", {31'b0, bus.wr_en}, 32'd0);
    check("midrst_wr_data", {24'b0, bus.wr_data}, 32'd0);
    check("midrst_miso", {31'b0, bus.miso}, 32'd1);
    check("midrst_overflow", {31'b0, bus.overflow}, 32'd0);
    check("midrst_frame_active", {31'b0, bus.frame_active}, 32'd0);
    bus.cs_n = 1'b1;
    bus.sclk = 1'b0;
    m_ovf    = 1'b0;
    exp_q.delete();
    wait_clk(5);
    wr_rst_n = 1'b1;
    wait_clk(5);
    frame_begin(1'b0);
    send_byte(8'hC3, 8);
    frame_end();

    // Overflow set and clear in the same cycle: set wins
    frame_begin(1'b1);
    send_byte(8'h12, 8);
    frame_end();
    frame_begin(1'b1);
    send_byte(8'h34, 8);
    frame_end();
    check("lit_status_ovf_full", {24'b0, first_miso}, 32'hC0);
    check("lit_overflow_kept", {31'b0, bus.overflow}, 32'd1);
    frame_begin(1'b0);
    send_byte(8'h56, 8);
    frame_end();
    check("lit_overflow_final", {31'b0, bus.overflow}, 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
